// File: rtl/tick_prescaler_pkg.sv
// Shared widths, FSM encoding and default terminal count for the tick prescaler.
package tick_pkg;

    localparam int unsigned COUNT_W = 24;
    localparam int unsigned SEL_W   = 8;

    localparam logic [COUNT_W-1:0] MAX_COUNT_DEFAULT = 24'd10_000_000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/tick_prescaler_input_filter.sv
// Synchronizes the asynchronous period selector and only accepts a value once it
// has been seen unchanged for STABLE_CYCLES consecutive clocks.
module input_filter
    import tick_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEL_W-1:0] sel_async_i,
    output logic [SEL_W-1:0] sel_stable_o
);

    localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

    logic [SYNC_STAGES-1:0][SEL_W-1:0] sync_q;
    logic [SEL_W-1:0]                  sel_sync;
    logic [SEL_W-1:0]                  cand_q, cand_d;
    logic [7:0]                        cnt_q, cnt_d;
    logic [SEL_W-1:0]                  stable_q, stable_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sel_async_i};
        end
    end

    assign sel_sync = sync_q[SYNC_STAGES-1];

    // cnt counts matching samples including the first one, saturating at the limit.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sel_sync != cand_q) begin
            cand_d = sel_sync;
            cnt_d  = 8'd1;
        end else if (cnt_q < STABLE_LIM) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (cnt_d >= STABLE_LIM) begin
            stable_d = cand_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign sel_stable_o = stable_q;

endmodule

// File: rtl/tick_prescaler.sv
// Programmable prescaler: emits a one-cycle tick every period+1 enabled cycles,
// with the period picked from a debounced selector at each wrap.
module tick_prescaler
    import tick_pkg::*;
#(
    parameter logic [COUNT_W-1:0] MAX_COUNT     = MAX_COUNT_DEFAULT,
    parameter int unsigned        SYNC_STAGES   = 2,
    parameter int unsigned        STABLE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ena,
    input  logic [SEL_W-1:0]   period_sel,
    output logic               tick,
    output logic [COUNT_W-1:0] count,
    output logic [COUNT_W-1:0] period,
    output logic               cfg_changed
);

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] period_q, period_d;
    logic               tick_q, tick_d;
    logic               cfg_q, cfg_d;
    logic [SEL_W-1:0]   sel_stable;
    logic [COUNT_W-1:0] target;

    input_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_input_filter (
        .clk          (clk),
        .reset        (reset),
        .sel_async_i  (period_sel),
        .sel_stable_o (sel_stable)
    );

    assign target = (sel_stable == '0) ? MAX_COUNT : {6'b0, sel_stable, 10'b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ena)  state_d = RUN;
            RUN:     if (!ena) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        period_d = period_q;
        tick_d   = 1'b0;
        cfg_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ena) begin
                    count_d  = '0;
                    period_d = target;
                end
            end
            RUN: begin
                if (ena) begin
                    if (count_q == period_q) begin
                        count_d  = '0;
                        period_d = target;
                        tick_d   = 1'b1;
                        cfg_d    = (target != period_q);
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            period_q <= MAX_COUNT;
            tick_q   <= 1'b0;
            cfg_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            period_q <= period_d;
            tick_q   <= tick_d;
            cfg_q    <= cfg_d;
        end
    end

    assign tick        = tick_q;
    assign count       = count_q;
    assign period      = period_q;
    assign cfg_changed = cfg_q;

endmodule

// File: tb/tb_tick_prescaler.sv
// Directed bench for tick_prescaler: expected ticks are queued when stimulus is
// applied and matched against the DUT by a per-cycle monitor.
module tb_tick_prescaler;

    logic        clk = 1'b0;
    logic        reset;
    logic        ena;
    logic [7:0]  period_sel;
    logic        tick;
    logic        cfg_changed;
    logic [23:0] count;
    logic [23:0] period;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int c0     = 0;

    typedef struct {
        int          at;
        logic [23:0] per;
        logic        cfg;
    } exp_t;

    exp_t exp_q[$];

    tick_prescaler #(
        .MAX_COUNT     (24'd20),
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ena         (ena),
        .period_sel  (period_sel),
        .tick        (tick),
        .count       (count),
        .period      (period),
        .cfg_changed (cfg_changed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic push(input int at, input logic [23:0] per, input logic cfg);
        exp_t e;
        e.at  = at;
        e.per = per;
        e.cfg = cfg;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Monitor: a tick must appear exactly at each queued cycle and nowhere else.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0 && cyc == exp_q[0].at) begin
            chk("tick_at_expected", 32'(tick), 32'd1);
            chk("tick_period", 32'(period), 32'(exp_q[0].per));
            chk("tick_cfg_changed", 32'(cfg_changed), 32'(exp_q[0].cfg));
            void'(exp_q.pop_front());
        end else begin
            if (tick)        chk("tick_unexpected", 32'(tick), 32'd0);
            if (cfg_changed) chk("cfg_unexpected", 32'(cfg_changed), 32'd0);
        end
    end

    initial begin
        reset      = 1'b0;
        ena        = 1'b0;
        period_sel = 8'h00;
        #1;
        reset = 1'b1;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_period", 32'(period), 32'd20);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_cfg", 32'(cfg_changed), 32'd0);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_count", 32'(count), 32'd0);

        // Default rate: tick every 21 cycles after the IDLE->RUN edge.
        ena = 1'b1;
        c0  = cyc + 1;
        push(c0 + 21, 24'd20, 1'b0);
        push(c0 + 42, 24'd20, 1'b0);
        push(c0 + 63, 24'd20, 1'b0);
        push(c0 + 84, 24'd20, 1'b0);
        wait_cyc(c0 + 84);

        // Glitch: three-cycle selector pulse must be rejected.
        push(c0 + 105, 24'd20, 1'b0);
        push(c0 + 126, 24'd20, 1'b0);
        period_sel = 8'h05;
        repeat (3) @(negedge clk);
        period_sel = 8'h00;
        wait_cyc(c0 + 100);
        chk("glitch_period", 32'(period), 32'd20);
        wait_cyc(c0 + 126);

        // Selector load: current interval completes, then period becomes 1024.
        period_sel = 8'h01;
        push(c0 + 147, 24'd1024, 1'b1);
        push(c0 + 1172, 24'd1024, 1'b0);
        push(c0 + 2197, 24'd1024, 1'b0);
        wait_cyc(c0 + 140);
        chk("midint_period", 32'(period), 32'd20);
        chk("midint_count", 32'(count), 32'd14);
        wait_cyc(c0 + 2197);

        // Back to default, then gate enable while count sits at the terminal value.
        period_sel = 8'h00;
        push(c0 + 3222, 24'd20, 1'b1);
        wait_cyc(c0 + 3242);
        chk("gate_pre_count", 32'(count), 32'd20);
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("gate_hold_count", 32'(count), 32'd20);
            chk("gate_hold_tick", 32'(tick), 32'd0);
        end
        ena = 1'b1;
        push(c0 + 3269, 24'd20, 1'b0);

        // Short asynchronous reset at count==7 aborts the interval.
        wait_cyc(c0 + 3276);
        chk("pre_rst_count", 32'(count), 32'd7);
        reset = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_period", 32'(period), 32'd20);
        chk("arst_tick", 32'(tick), 32'd0);
        chk("arst_cfg", 32'(cfg_changed), 32'd0);
        reset = 1'b0;
        #1;
        push(c0 + 3298, 24'd20, 1'b0);
        wait_cyc(c0 + 3300);
        chk("pending_ticks", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tick_prescaler.md
TICK_PRESCALER -- requirements
Module: tick_prescaler

Interface
REQ-001 Parameter MAX_COUNT, default 24'd10_000_000: terminal count used when the selector is zero.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for period_sel, legal range 2..4.
REQ-003 Parameter STABLE_CYCLES, default 16: consecutive equal samples needed to accept a new selector value, legal range 1..255.
REQ-004 clk  input  1: single clock; all state is updated on the rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 ena  input  1: count enable, synchronous to clk.
REQ-007 period_sel  input  8: raw switch value, asynchronous to clk.
REQ-008 tick  output  1: one-cycle pulse at each wrap; this feeds the downstream digit counter.
REQ-009 count  output  24: current prescaler count.
REQ-010 period  output  24: active terminal count.
REQ-011 cfg_changed  output  1: one-cycle pulse when a wrap loads a period that differs from the previous one.

Function
REQ-012 period_sel SHALL pass through SYNC_STAGES flops before any use; the result is sel_sync.
REQ-013 The filter SHALL update sel_stable to sel_sync only after sel_sync has held the same value for STABLE_CYCLES consecutive cycles.
REQ-014 Any change in sel_sync SHALL restart the stability count.
REQ-015 target SHALL be MAX_COUNT when sel_stable==0, else {6'b0, sel_stable, 10'b0}; the minimum non-default target is 1024.
REQ-016 FSM states: IDLE and RUN.
- IDLE->RUN when ena==1.
- RUN->IDLE when ena==0.
REQ-017 On the IDLE->RUN edge the block SHALL clear count to 0 and load period from target; tick SHALL stay 0 in that cycle.
REQ-018 In RUN with count!=period, count SHALL increment by 1.
REQ-019 In RUN with count==period, on the same edge:
- count SHALL become 0.
- tick SHALL be 1 for exactly that next cycle.
- period SHALL load target.
REQ-020 The tick spacing SHALL therefore be period+1 cycles.
REQ-021 cfg_changed SHALL pulse for one cycle, coincident with tick, when the newly loaded period differs from the old one.
REQ-022 A selector change mid-interval SHALL NOT alter the current interval; it takes effect only at the next wrap.
REQ-023 In RUN->IDLE, count and period SHALL hold their values, and tick and cfg_changed SHALL be 0.
REQ-024 If ena==0 in a cycle where count==period, the block SHALL NOT wrap and SHALL NOT tick.
REQ-025 count SHALL never exceed period; the 24-bit arithmetic needs no overflow handling.

Reset
REQ-026 While reset is high, the following SHALL apply immediately, independent of clk:
- count=0, period=MAX_COUNT, tick=0, cfg_changed=0.
- All synchronizer flops=0, sel_stable=0, stability counter=0.
- FSM state=IDLE.
REQ-027 Asserting reset mid-interval SHALL abort the interval with no tick emitted.
REQ-028 After reset deasserts, counting SHALL resume only through the IDLE->RUN edge (REQ-017).

Structure
REQ-029 Shared package tick_pkg SHALL hold:
- COUNT_W=24 and SEL_W=8.
- The FSM state enum (IDLE, RUN).
- The default MAX_COUNT constant.
REQ-030 The synchronizer plus stability filter SHALL be a sub-module named input_filter, parameterized by SYNC_STAGES and STABLE_CYCLES.
REQ-031 The counter, FSM and target mapping SHALL live in tick_prescaler.

Verification (MAX_COUNT=20, STABLE_CYCLES=4 unless stated)
REQ-032 Default rate: period_sel=0, ena=1 for 100 cycles -> tick every 21 cycles; period=20; cfg_changed never pulses.
REQ-033 Selector load: period_sel=8'h01 held -> the current 20-cycle interval completes; the next wrap loads period=1024 with cfg_changed=1; subsequent ticks occur every 1025 cycles.
REQ-034 Glitch rejection: period_sel pulses 8'h05 for 3 cycles, then returns to 0 -> sel_stable stays 0 and period stays 20.
REQ-035 Enable gating: ena drops at count==20 for 5 cycles -> no tick while ena==0 and count holds at 20; on re-enable, count restarts from 0 and the first tick arrives 21 cycles later.
REQ-036 Async reset: reset pulses for less than one clock period at count==7 -> count=0, period=20 and tick=0 immediately, without waiting for a clock edge.
